// File: rtl/bru_pkg.sv
// -----------------------------------------------------------------------------
// bru_pkg
//   Shared types and constants for the branch resolve unit.
//   - cause_e      : 3-bit mispredict cause code driven on mispred_cause_E
//   - pred_entry_t : one prediction pipeline register {valid, pred_valid, pred_pc}
//   - PC_STEP      : sequential fetch increment
//   `NOBRANCH normally comes from the shared Parameters.v; a guarded fallback
//   is provided so this slice elaborates on its own.
// -----------------------------------------------------------------------------
`ifndef NOBRANCH
`define NOBRANCH 3'd0
`endif

package bru_pkg;

    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [2:0] {
        NONE         = 3'd0,
        MISS         = 3'd1,
        WRONG_TARGET = 3'd2,
        NOT_TAKEN    = 3'd3,
        NOT_BRANCH   = 3'd4
    } cause_e;

    typedef struct packed {
        logic        valid;
        logic        pred_valid;
        logic [31:0] pred_pc;
    } pred_entry_t;

endpackage

// File: rtl/pred_stage_reg.sv
// -----------------------------------------------------------------------------
// pred_stage_reg
//   One prediction pipeline register. Update priority: rst > clear > stall > load.
//   Ports:
//     clk, rst   : clock, asynchronous active-high reset
//     clear      : write an all-zero (invalid) entry
//     stall      : hold the current entry
//     load_entry : entry captured when neither clear nor stall is asserted
//     entry      : registered entry
// -----------------------------------------------------------------------------
module pred_stage_reg
    import bru_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        stall,
    input  pred_entry_t load_entry,
    output pred_entry_t entry
);

    // NOTE: state is written with non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry <= '0;
        end else if (clear) begin
            entry <= '0;
        end else if (!stall) begin
            entry <= load_entry;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//   Carries BTB predictions F->D->E, checks them against the resolved branch
//   in E, raises a one-cycle redirect with a cause code and drives BTB
//   fill/correct writes.
//   Optional feature macro: BRU_STATS_EN (prediction statistics counters).
//   Ports:
//     clk, rst                       : clock, asynchronous active-high reset
//     pred_valid_F, pred_pc_F        : BTB hit / predicted target for F
//     stall_D, flush_D               : hold / clear of the F->D register
//     stall_E, flush_E               : hold / clear of the D->E register
//     PC_E, br_type_E, branch_E,
//     target_E                       : resolved branch information in E
//     mispredict_E, redirect_PC_E,
//     mispred_cause_E                : redirect request, corrected PC, cause
//     btb_wr_en, btb_wr_pc,
//     btb_wr_target                  : BTB write port
//     br_cnt, mispred_cnt            : saturating statistics (0 when disabled)
// -----------------------------------------------------------------------------
`ifndef NOBRANCH
`define NOBRANCH 3'd0
`endif

module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pred_valid_F,
    input  logic [31:0]      pred_pc_F,
    input  logic             stall_D,
    input  logic             flush_D,
    input  logic             stall_E,
    input  logic             flush_E,
    input  logic [31:0]      PC_E,
    input  logic [2:0]       br_type_E,
    input  logic             branch_E,
    input  logic [31:0]      target_E,
    output logic             mispredict_E,
    output logic [31:0]      redirect_PC_E,
    output logic [2:0]       mispred_cause_E,
    output logic             btb_wr_en,
    output logic [31:0]      btb_wr_pc,
    output logic [31:0]      btb_wr_target,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    pred_entry_t fd_load;
    pred_entry_t fd_q;
    pred_entry_t de_q;
    logic        act;
    logic        is_br;
    cause_e      cause;

    assign fd_load = '{valid: 1'b1, pred_valid: pred_valid_F, pred_pc: pred_pc_F};

    // A mispredict squashes both younger wrong-path entries at the next edge.
    pred_stage_reg u_fd (
        .clk        (clk),
        .rst        (rst),
        .clear      (flush_D | mispredict_E),
        .stall      (stall_D),
        .load_entry (fd_load),
        .entry      (fd_q)
    );

    pred_stage_reg u_de (
        .clk        (clk),
        .rst        (rst),
        .clear      (flush_E | mispredict_E),
        .stall      (stall_E),
        .load_entry (fd_q),
        .entry      (de_q)
    );

    // A stalled instruction is resolved only in the cycle it leaves E, so it
    // cannot redirect twice.
    assign act   = de_q.valid & ~stall_E;
    assign is_br = (br_type_E != `NOBRANCH);

    // Resolution: ordered checks, first match wins. A correct taken
    // prediction falls through to NONE.
    always_comb begin
        // NOTE: defaulting every comb output first keeps the block latch-free.
        cause = NONE;
        if (act) begin
            if (!is_br && de_q.pred_valid) begin
                cause = NOT_BRANCH;
            end else if (is_br && branch_E && !de_q.pred_valid) begin
                cause = MISS;
            end else if (is_br && branch_E && (de_q.pred_pc != target_E)) begin
                cause = WRONG_TARGET;
            end else if (is_br && !branch_E && de_q.pred_valid) begin
                cause = NOT_TAKEN;
            end
        end
    end

    always_comb begin
        mispredict_E  = (cause != NONE);
        redirect_PC_E = '0;
        btb_wr_en     = 1'b0;
        btb_wr_pc     = '0;
        btb_wr_target = '0;
        unique case (cause)
            MISS, WRONG_TARGET: begin
                redirect_PC_E = target_E;
                btb_wr_en     = 1'b1;
                btb_wr_pc     = PC_E;
                btb_wr_target = target_E;
            end
            NOT_TAKEN, NOT_BRANCH: begin
                // 32-bit add wraps 0xFFFFFFFC to 0.
                redirect_PC_E = PC_E + PC_STEP;
            end
            default: ;
        endcase
    end

    assign mispred_cause_E = cause;

`ifdef BRU_STATS_EN
    logic [CNT_W-1:0] br_q;
    logic [CNT_W-1:0] mis_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_q  <= '0;
            mis_q <= '0;
        end else begin
            if (act && is_br && (br_q != {CNT_W{1'b1}})) begin
                br_q <= br_q + CNT_W'(1);
            end
            if (mispredict_E && (mis_q != {CNT_W{1'b1}})) begin
                mis_q <= mis_q + CNT_W'(1);
            end
        end
    end

    assign br_cnt      = br_q;
    assign mispred_cnt = mis_q;
`else
    assign br_cnt      = '0;
    assign mispred_cnt = '0;
`endif

endmodule
